alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the team's 32-bit combinational ALU. It keeps the eight legacy operations on op codes 0–7 and adds XOR, logical shifts and an optional iterative multiply, widening the op code to 4 bits. Results and status flags are registered, and both input and output use valid/ready handshakes. The block sits between an operand-issue stage and a writeback stage that may stall it.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- Clock and reset:
  - clk, input, 1, rising-edge clock.
  - rst_n, input, 1, reset; asynchronous, active-low.
- Input handshake:
  - in_valid, input, 1, operands and op code are valid.
  - in_ready, output, 1, block accepts the operation this cycle.
  - Op_code, input, 4, operation select.
  - A, input, WIDTH, operand A.
  - B, input, WIDTH, operand B.
- Output handshake:
  - out_valid, output, 1, Y and flags hold a result.
  - out_ready, input, 1, consumer takes the result this cycle.
  - Y, output, WIDTH, result.
- Flags:
  - flag_z, output, 1, result is zero.
  - flag_n, output, 1, result MSB.
  - flag_c, output, 1, carry/no-borrow.
  - flag_v, output, 1, signed overflow.

## Operation
- Op codes:
  - 0: Y=A
  - 1: A+B
  - 2: A−B
  - 3: A&B
  - 4: A|B
  - 5: A+1
  - 6: A−1
  - 7: Y=B
  - 8: A^B
  - 9: A<<B[SHW-1:0]
  - 10: A>>B[SHW-1:0] (logical)
  - 11: low WIDTH bits of A*B (unsigned)
  - 12–15: Y=0
- Arithmetic is modulo 2^WIDTH.
- flag_c:
  - Ops 1 and 5: carry out of bit WIDTH-1.
  - Ops 2 and 6: carry out of A+~B+1, i.e. 1 when no borrow. For op 6, B is taken as 1.
  - All other ops: 0.
- flag_v (signed two's-complement overflow):
  - Ops 1, 2, 5, 6: 1 on signed overflow.
  - All other ops: 0.
- flag_z and flag_n are computed from Y for every op.
- State machine:
  - IDLE:
    - The transfer fires when in_valid && in_ready.
    - A non-multiply op loads Y and the flags into the output register, sets out_valid, and stays in IDLE.
    - Op 11 captures A, B and clears the accumulator and counter, then moves to MUL.
  - MUL:
    - One shift-add step per cycle for WIDTH cycles.
    - On the last step the result loads into the output register, out_valid sets, and the FSM returns to IDLE.
    - If out_valid is still high from an earlier unconsumed result, the FSM waits in MUL with the accumulator frozen.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full throughput.
- out_valid clears on out_valid && out_ready unless a new result loads in the same cycle; a new result takes priority.
- Y and the flags hold stable while out_valid && !out_ready.
- In MUL, input operands and Op_code are ignored; only the captured copies are used.

## Timing
- Reset values (asynchronous on rst_n low):
  - state=IDLE
  - out_valid=0, Y=0, all flags=0
  - counter=0, accumulator=0
  - in_ready=0 while rst_n is low.
- Reset mid-multiply aborts the operation and discards the result.
- Single-cycle ops: the transfer at edge E gives out_valid=1 and the result after E (latency 1).
- Multiply: the transfer at edge E gives out_valid=1 after edge E+WIDTH (latency WIDTH), assuming the output register is free.
- Simultaneous output drain and new input transfer in IDLE: the new result replaces the old one and out_valid stays 1.
- No combinational path from in_valid or operands to any output.
- Combinational path from out_ready to in_ready.

## Configuration
- ALU_SEQ_MUL_EN:
  - Defined: op 11 is the WIDTH-cycle multiplier described above, and the MUL state, counter and accumulator are built.
  - Undefined: op 11 behaves as ops 12–15 (single cycle, Y=0, flag_z=1), and there is no MUL state or multiplier logic.

## Test plan
WIDTH=32 unless noted.
- Reset: hold rst_n=0 with random inputs → out_valid=0, Y=0, flags=0, in_ready=0. Release → in_ready=1.
- Add overflow: op1, A=0x7FFFFFFF, B=1 → one cycle later Y=0x80000000, n=1, v=1, c=0, z=0. Then op1, A=0xFFFFFFFF, B=1 → Y=0, z=1, c=1, v=0.
- Back-pressure: op2, A=5, B=7 with out_ready=0 → Y=0xFFFFFFFE, c=0, n=1. Y holds and in_ready=0 for 3 cycles. Raising out_ready with in_valid op8 A=0xF0, B=0xFF in the same cycle → next Y=0x0F, out_valid stays 1.
- Shifts: op9, A=1, B=0x23 → Y=0x8 (amount is 3). Op10, A=0x80000000, B=31 → Y=1.
- Multiply (macro defined): op11, A=0x10001, B=0x10001 → in_ready=0 for 32 cycles, out_valid after 32 edges, Y=0x00020001. Asserting rst_n=0 at cycle 10 of a repeat → no result, FSM back to IDLE.
- Multiply (macro undefined): op11, A=3, B=4 → after 1 cycle Y=0, z=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq -- registered ALU with valid/ready handshakes on both sides.
//
// Op codes 0-7 are the legacy ALU set (pass A, add, sub, and, or, inc,
// dec, pass B). 8 is XOR, 9/10 are logical shifts by B[SHW-1:0], 11 is an
// unsigned multiply (low WIDTH bits), and 12-15 return zero.
// Single-cycle ops have a latency of one clock. The multiply is a WIDTH-cycle
// shift-add sequence.
//
// Build option:
//   ALU_SEQ_MUL_EN  defined   -> op 11 runs the iterative multiplier.
//                   undefined -> op 11 returns zero in one cycle, and no
//                                multiplier state is built.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operation handshake (Op_code, A, B)
//   out_valid/out_ready   result handshake (Y, flag_z/n/c/v)
//   flag_z  result is zero         flag_n  result MSB
//   flag_c  carry / no-borrow      flag_v  signed overflow
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Op_code,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam logic [3:0] OP_PASS_A = 4'd0;
  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_SUB    = 4'd2;
  localparam logic [3:0] OP_AND    = 4'd3;
  localparam logic [3:0] OP_OR     = 4'd4;
  localparam logic [3:0] OP_INC    = 4'd5;
  localparam logic [3:0] OP_DEC    = 4'd6;
  localparam logic [3:0] OP_PASS_B = 4'd7;
  localparam logic [3:0] OP_XOR    = 4'd8;
  localparam logic [3:0] OP_SHL    = 4'd9;
  localparam logic [3:0] OP_SHR    = 4'd10;
  localparam logic [3:0] OP_MUL    = 4'd11;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  // All four arithmetic ops share one adder: A + add_b + add_cin.
  // Subtraction uses ~operand + 1, so the carry out is the "no borrow" flag.
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_v;

  always_comb begin
    add_b   = B;
    add_cin = 1'b0;
    unique case (Op_code)
      OP_SUB: begin
        add_b   = ~B;
        add_cin = 1'b1;
      end
      OP_INC: begin
        add_b   = WIDTH'(1);
        add_cin = 1'b0;
      end
      OP_DEC: begin
        add_b   = ~WIDTH'(1);
        add_cin = 1'b1;
      end
      default: begin
        add_b   = B;
        add_cin = 1'b0;
      end
    endcase
  end

  assign add_sum = {1'b0, A} + {1'b0, add_b} + (WIDTH + 1)'(add_cin);
  // Overflow: both addends share a sign and the sum's sign differs from it.
  assign add_v   = (A[WIDTH-1] == add_b[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != A[WIDTH-1]);

  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (Op_code)
      OP_PASS_A: alu_y = A;
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        alu_y = add_sum[WIDTH-1:0];
        alu_c = add_sum[WIDTH];
        alu_v = add_v;
      end
      OP_AND:    alu_y = A & B;
      OP_OR:     alu_y = A | B;
      OP_PASS_B: alu_y = B;
      OP_XOR:    alu_y = A ^ B;
      OP_SHL:    alu_y = A << B[SHW-1:0];
      OP_SHR:    alu_y = A >> B[SHW-1:0];
      // Op 11 (when the multiplier is absent) and 12-15 return zero.
      default:   alu_y = '0;
    endcase
  end

  logic in_fire;
  logic load_alu;
  logic load_mul;
  logic [WIDTH-1:0] mul_y;

`ifdef ALU_SEQ_MUL_EN
  // ---------------------------------------------------------------------------
  // Iterative multiplier: one partial product per cycle, LSB of B first.
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] mul_a_reg;
  logic [WIDTH-1:0] mul_b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [SHW-1:0]   cnt_reg;
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH-1:0] acc_next;
  logic             mul_start;
  logic             mul_step;
  logic             is_mul;

  // Partial product of the shifted multiplicand with the current multiplier bit.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
    assign mul_addend[gi] = mul_a_reg[gi] & mul_b_reg[0];
  end

  assign acc_next = acc_reg + mul_addend;
  assign is_mul   = (Op_code == OP_MUL);
  assign in_ready = rst_n && (state_reg == ST_IDLE) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign load_alu = in_fire && !is_mul;
  assign mul_y    = acc_next;

  always_comb begin
    state_next = state_reg;
    mul_start  = 1'b0;
    mul_step   = 1'b0;
    load_mul   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_fire && is_mul) begin
          mul_start  = 1'b1;
          state_next = ST_MUL;
        end
      end
      ST_MUL: begin
        // The final step must deposit into the output register, so it is held
        // back while an older result is still waiting to be consumed.
        if ((cnt_reg != CNT_LAST) || !out_valid || out_ready) begin
          mul_step = 1'b1;
          if (cnt_reg == CNT_LAST) begin
            load_mul   = 1'b1;
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_reg <= '0;
      mul_b_reg <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (mul_start) begin
      mul_a_reg <= A;
      mul_b_reg <= B;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (mul_step) begin
      mul_a_reg <= mul_a_reg << 1;
      mul_b_reg <= mul_b_reg >> 1;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_reg + SHW'(1);
    end
  end
`else
  assign in_ready = rst_n && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign load_alu = in_fire;
  assign load_mul = 1'b0;
  assign mul_y    = '0;
`endif

  // ---------------------------------------------------------------------------
  // Output register. A new result wins over a drain in the same cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Y         <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (load_alu) begin
      out_valid <= 1'b1;
      Y         <= alu_y;
      flag_z    <= (alu_y == '0);
      flag_n    <= alu_y[WIDTH-1];
      flag_c    <= alu_c;
      flag_v    <= alu_v;
    end else if (load_mul) begin
      out_valid <= 1'b1;
      Y         <= mul_y;
      flag_z    <= (mul_y == '0);
      flag_n    <= mul_y[WIDTH-1];
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32): directed cases followed by randomized
// traffic, all compared against a cycle-level transaction model.
module tb_alu_seq;

  localparam int WIDTH = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        Op_code;
  logic [WIDTH-1:0]  A;
  logic [WIDTH-1:0]  B;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  Y;
  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              flag_v;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Op_code   (Op_code),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: returns {y, z, n, c, v} from plain integer arithmetic.
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua;
    longint unsigned ub;
    longint          sa;
    longint          sb;
    longint          r;
    longint          lim;
    logic [31:0]     y;
    logic            c;
    logic            v;
    ua  = a;
    ub  = b;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    lim = 64'sh80000000;
    y = 32'd0;
    c = 1'b0;
    v = 1'b0;
    if (op == 4'd5) begin ub = 1; sb = 1; end
    if (op == 4'd6) begin ub = 1; sb = 1; end
    case (op)
      4'd0: y = a;
      4'd1, 4'd5: begin
        y = 32'(ua + ub);
        c = ((ua + ub) >> 32) != 0;
        r = sa + sb;
        v = (r >= lim) || (r < -lim);
      end
      4'd2, 4'd6: begin
        y = 32'(ua - ub);
        c = (ua >= ub);
        r = sa - sb;
        v = (r >= lim) || (r < -lim);
      end
      4'd3: y = a & b;
      4'd4: y = a | b;
      4'd7: y = b;
      4'd8: y = a ^ b;
      4'd9: y = a << b[4:0];
      4'd10: y = a >> b[4:0];
`ifdef ALU_SEQ_MUL_EN
      4'd11: y = 32'(ua * ub);
`endif
      default: y = 32'd0;
    endcase
    return {y, (y == 32'd0), y[31], c, v};
  endfunction

  // Transaction-level model state.
  logic        m_valid;
  logic [35:0] m_res;
  logic [35:0] m_mul;
  int          m_busy;

  // One clock: check in_ready before the edge, update the model at the edge,
  // check the output register just after it. Called at posedge+1.
  task automatic cycle();
    logic        exp_rdy;
    logic [35:0] r;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_busy  = 0;
      m_res   = '0;
    end
    exp_rdy = rst_n && (m_busy == 0) && (!m_valid || out_ready);
    #2;
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    @(posedge clk);
    if (rst_n) begin
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1'b1;
          m_res   = m_mul;
        end
      end
      if (in_valid && exp_rdy) begin
        r = ref_alu(Op_code, A, B);
`ifdef ALU_SEQ_MUL_EN
        if (Op_code == 4'd11) begin
          m_busy = WIDTH;
          m_mul  = r;
        end else begin
          m_valid = 1'b1;
          m_res   = r;
        end
`else
        m_valid = 1'b1;
        m_res   = r;
`endif
      end
    end
    #1;
    $display("cyc t=%0t rst_n=%0b in_v=%0b op=%0d A=%08h B=%08h out_v=%0b Y=%08h znvc=%0b%0b%0b%0b",
             $time, rst_n, in_valid, Op_code, A, B, out_valid, Y, flag_z, flag_n, flag_v, flag_c);
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    if (m_valid || !rst_n) begin
      check("Y", {32'd0, Y}, {32'd0, m_res[35:4]});
      check("flags_zncv", {60'd0, flag_z, flag_n, flag_c, flag_v}, {60'd0, m_res[3:0]});
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic ordy);
    in_valid  = 1'b1;
    Op_code   = op;
    A         = a;
    B         = b;
    out_ready = ordy;
  endtask

  task automatic idle(input logic ordy);
    in_valid  = 1'b0;
    Op_code   = 4'($urandom);
    A         = $urandom;
    B         = $urandom;
    out_ready = ordy;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_valid = 1'b0;
    m_busy  = 0;
    m_res   = '0;
    m_mul   = '0;

    // Reset held with random inputs.
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      Op_code   = 4'($urandom);
      A         = $urandom;
      B         = $urandom;
      cycle();
    end
    rst_n = 1'b1;
    idle(1'b1);
    cycle();

    // Add overflow cases.
    issue(4'd1, 32'h7FFF_FFFF, 32'h1, 1'b1);
    cycle();
    check("add_ovf_y", {32'd0, Y}, 64'h8000_0000);
    check("add_ovf_flags", {60'd0, flag_z, flag_n, flag_c, flag_v}, 64'b0101);
    issue(4'd1, 32'hFFFF_FFFF, 32'h1, 1'b1);
    cycle();
    check("add_wrap_y", {32'd0, Y}, 64'h0);
    check("add_wrap_flags", {60'd0, flag_z, flag_n, flag_c, flag_v}, 64'b1010);
    idle(1'b1);
    cycle();

    // Back-pressure.
    issue(4'd2, 32'd5, 32'd7, 1'b0);
    cycle();
    check("sub_y", {32'd0, Y}, 64'hFFFF_FFFE);
    check("sub_flags", {60'd0, flag_z, flag_n, flag_c, flag_v}, 64'b0100);
    idle(1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_y", {32'd0, Y}, 64'hFFFF_FFFE);
    end
    issue(4'd8, 32'h0000_00F0, 32'h0000_00FF, 1'b1);
    cycle();
    check("xor_replace_y", {32'd0, Y}, 64'h0F);
    check("xor_replace_valid", {63'd0, out_valid}, 64'd1);

    // Shifts.
    issue(4'd9, 32'h1, 32'h23, 1'b1);
    cycle();
    check("shl_y", {32'd0, Y}, 64'h8);
    issue(4'd10, 32'h8000_0000, 32'd31, 1'b1);
    cycle();
    check("shr_y", {32'd0, Y}, 64'h1);
    idle(1'b1);
    cycle();

`ifdef ALU_SEQ_MUL_EN
    issue(4'd11, 32'h0001_0001, 32'h0001_0001, 1'b1);
    cycle();
    idle(1'b1);
    for (int i = 0; i < WIDTH; i++) cycle();
    check("mul_y", {32'd0, Y}, 64'h0002_0001);
    idle(1'b1);
    cycle();
    // Repeat and abort with reset partway through.
    issue(4'd11, 32'h0001_0001, 32'h0001_0001, 1'b1);
    cycle();
    idle(1'b1);
    for (int i = 0; i < 9; i++) cycle();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 4; i++) cycle();
    check("mul_abort_valid", {63'd0, out_valid}, 64'd0);
`else
    issue(4'd11, 32'd3, 32'd4, 1'b1);
    cycle();
    check("mul_off_y", {32'd0, Y}, 64'h0);
    check("mul_off_z", {63'd0, flag_z}, 64'd1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        issue(4'($urandom), pick_operand(), pick_operand(), 1'($urandom_range(0, 9) < 7));
      end else begin
        idle(1'($urandom_range(0, 9) < 7));
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
